// File: rtl/wb_burst_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : if_wb
//  Purpose  : Pipelined Wishbone bus bundle shared by an initiator and a
//             target.
//  Ports    : clk, rst - bus-side clock/reset (carried for completeness).
//  Signals  : cyc, stb, we, adr, dat_o (initiator -> target)
//             ack, stall, dat_i        (target -> initiator)
//  Revision : 1.0 - initial release
// ============================================================================
interface if_wb #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input logic clk,
  input logic rst
);
  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_o;
  logic          ack;
  logic          stall;
  logic [DW-1:0] dat_i;

  modport master (
    output cyc, stb, we, adr, dat_o,
    input  ack, stall, dat_i
  );

  modport slave (
    input  cyc, stb, we, adr, dat_o,
    output ack, stall, dat_i
  );
endinterface
`default_nettype wire

// File: rtl/wb_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module   : wb_burst_reader
//  Purpose  : Issues a burst of pipelined Wishbone reads from consecutive
//             word addresses and streams the returned words out, with a
//             watchdog that aborts a stalled burst.
//  Ports    : clk, rst_n       - clock, asynchronous active-low reset
//             wb               - pipelined Wishbone initiator
//             start/base/len   - burst request (sampled in IDLE only)
//             dout/dout_valid  - registered read data and its strobe
//             busy             - high whenever a burst is in progress
//             done/err         - end-of-burst pulse, err marks a timeout
//  Revision : 1.0 - initial release
// ============================================================================
module wb_burst_reader #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int LENW    = 9,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  if_wb.master            wb,
  input  logic            start,
  input  logic [AW-1:0]   base,
  input  logic [LENW-1:0] len,
  output logic [DW-1:0]   dout,
  output logic            dout_valid,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int              c_WD_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [c_WD_W:0] c_WD_LIMIT = (c_WD_W + 1)'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [AW-1:0]       r_adr;
  logic [LENW-1:0]     r_len;
  logic [LENW-1:0]     r_issued;
  logic [LENW-1:0]     r_acked;
  logic [c_WD_W-1:0]   r_wd;
  logic [DW-1:0]       r_dout;
  logic                r_dout_valid;
  logic                r_done;
  logic                r_err;

  logic                w_active;
  logic                w_accept;
  logic                w_ack_ok;
  logic [LENW-1:0]     w_issued_nxt;
  logic [LENW-1:0]     w_acked_nxt;
  logic [c_WD_W:0]     w_wd_inc;
  logic                w_wd_expire;
  logic                w_load;
  logic                w_done_nxt;
  logic                w_err_nxt;

  assign w_active = (r_state != S_IDLE);
  assign w_accept = (r_state == S_ISSUE) && !wb.stall;

  // An ack is only meaningful if it answers an outstanding request; the
  // request accepted this very cycle counts as outstanding so a
  // combinational-ack target is handled too.
  assign w_ack_ok = w_active && wb.ack &&
                    ({1'b0, r_acked} < ({1'b0, r_issued} + {{LENW{1'b0}}, w_accept}));

  assign w_issued_nxt = r_issued + {{(LENW-1){1'b0}}, w_accept};
  assign w_acked_nxt  = r_acked  + {{(LENW-1){1'b0}}, w_ack_ok};

  // The abort fires on the idle cycle whose increment would bring the
  // watchdog to TIMEOUT, so the exit cycle lands TIMEOUT+1 cycles after
  // the last bus event.
  assign w_wd_inc    = {1'b0, r_wd} + {{c_WD_W{1'b0}}, 1'b1};
  assign w_wd_expire = w_active && !w_accept && !w_ack_ok && (w_wd_inc >= c_WD_LIMIT);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and per-cycle controls
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            w_state_nxt = S_ISSUE;
            w_load      = 1'b1;
          end else begin
            w_done_nxt  = 1'b1;
          end
        end
      end
      S_ISSUE, S_DRAIN: begin
        if (w_acked_nxt == r_len) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else if (w_wd_expire) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_err_nxt   = 1'b1;
        end else if ((r_state == S_ISSUE) && (w_issued_nxt == r_len)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: address, counters, watchdog, read data
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_adr        <= '0;
      r_len        <= '0;
      r_issued     <= '0;
      r_acked      <= '0;
      r_wd         <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_dout_valid <= w_ack_ok;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
      if (w_ack_ok) begin
        r_dout <= wb.dat_i;
      end

      if (w_load) begin
        r_adr    <= base;
        r_len    <= len;
        r_issued <= '0;
        r_acked  <= '0;
      end else if (w_active) begin
        r_issued <= w_issued_nxt;
        r_acked  <= w_acked_nxt;
        if (w_accept) begin
          r_adr <= r_adr + AW'(1);
        end
      end

      if (w_load || (w_state_nxt == S_IDLE) || w_accept || w_ack_ok) begin
        r_wd <= '0;
      end else if (w_active) begin
        r_wd <= w_wd_inc[c_WD_W-1:0];
      end
    end
  end

  assign wb.cyc     = w_active;
  assign wb.stb     = (r_state == S_ISSUE);
  assign wb.we      = 1'b0;
  assign wb.adr     = r_adr;
  assign wb.dat_o   = '0;

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy       = w_active;
  assign done       = r_done;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_burst_reader
//  Purpose  : Directed self-checking bench for wb_burst_reader with a small
//             pipelined Wishbone target (data = address ^ 0x5A00).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_burst_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst_hi;
  logic        start = 1'b0;
  logic [15:0] base = 16'h0;
  logic [8:0]  len = 9'h0;
  logic [15:0] dout;
  logic        dout_valid;
  logic        busy;
  logic        done;
  logic        err;

  logic        ack_en = 1'b1;
  logic        wait_en = 1'b0;
  logic        force_ack = 1'b0;
  logic        s_ack;
  logic        s_held;
  logic [15:0] s_dat;

  int          n_checks = 0;
  int          n_errs = 0;

  logic        t_stb [0:31];
  logic        t_cyc [0:31];
  logic        t_dv  [0:31];
  logic        t_done[0:31];
  logic        t_err [0:31];
  logic [15:0] t_adr [0:31];
  logic [15:0] dq[$];

  assign rst_hi = ~rst_n;

  if_wb #(.AW(16), .DW(16)) bus (.clk(clk), .rst(rst_hi));

  wb_burst_reader #(
    .AW(16), .DW(16), .LENW(9), .TIMEOUT(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb        (bus),
    .start     (start),
    .base      (base),
    .len       (len),
    .dout      (dout),
    .dout_valid(dout_valid),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Target model: acks one cycle after acceptance; in wait mode every new
  // request is stalled for its first stb cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ack  <= 1'b0;
      s_held <= 1'b0;
      s_dat  <= 16'h0;
    end else begin
      s_held <= bus.stb & bus.stall;
      s_ack  <= ack_en & bus.cyc & bus.stb & ~bus.stall;
      s_dat  <= bus.adr ^ 16'h5A00;
    end
  end

  assign bus.ack   = s_ack | force_ack;
  assign bus.stall = wait_en & bus.stb & ~s_held;
  assign bus.dat_i = s_dat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Start pulse in cycle 0, then record cycles 1..n at the falling edge.
  task automatic run(input logic [15:0] b, input logic [8:0] l, input int n,
                     input int stray_at, input int busy_start_at);
    dq.delete();
    @(posedge clk); #1;
    start = 1'b1; base = b; len = l;
    @(posedge clk); #1;
    start = 1'b0; base = 16'h0; len = 9'h0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      t_stb[k]  = bus.stb;
      t_cyc[k]  = bus.cyc;
      t_dv[k]   = dout_valid;
      t_done[k] = done;
      t_err[k]  = err;
      t_adr[k]  = bus.adr;
      if (dout_valid) dq.push_back(dout);
      force_ack = (k == stray_at);
      if (k == busy_start_at) begin
        start = 1'b1; base = 16'h0099; len = 9'd1;
      end else begin
        start = 1'b0;
      end
    end
    force_ack = 1'b0;
    start = 1'b0;
  endtask

  function automatic int first_done(input int n);
    for (int k = 1; k <= n; k++) if (t_done[k]) return k;
    return -1;
  endfunction

  function automatic int cnt_done(input int n);
    int c = 0;
    for (int k = 1; k <= n; k++) if (t_done[k]) c++;
    return c;
  endfunction

  function automatic int cnt_err(input int n);
    int c = 0;
    for (int k = 1; k <= n; k++) if (t_err[k]) c++;
    return c;
  endfunction

  function automatic int cnt_stb(input int n);
    int c = 0;
    for (int k = 1; k <= n; k++) if (t_stb[k]) c++;
    return c;
  endfunction

  function automatic int cnt_cyc(input int n);
    int c = 0;
    for (int k = 1; k <= n; k++) if (t_cyc[k]) c++;
    return c;
  endfunction

  logic [15:0] e_adr1[4] = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
  logic [15:0] e_dat1[4] = '{16'h5A10, 16'h5A11, 16'h5A12, 16'h5A13};
  logic [15:0] e_adr2[6] = '{16'h0020, 16'h0020, 16'h0021, 16'h0021, 16'h0022, 16'h0022};
  logic [15:0] e_dat2[3] = '{16'h5A20, 16'h5A21, 16'h5A22};
  logic [15:0] e_adr3[4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
  logic [15:0] e_dat3[4] = '{16'hA5FE, 16'hA5FF, 16'h5A00, 16'h5A01};
  logic [15:0] e_dat6[2] = '{16'h5A40, 16'h5A41};

  initial begin
    int c_done;
    int c_dv;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cyc",   bus.cyc,    0);
    chk("rst_stb",   bus.stb,    0);
    chk("rst_we",    bus.we,     0);
    chk("rst_adr",   bus.adr,    0);
    chk("rst_dat_o", bus.dat_o,  0);
    chk("rst_dout",  dout,       0);
    chk("rst_dv",    dout_valid, 0);
    chk("rst_busy",  busy,       0);
    chk("rst_done",  done,       0);
    chk("rst_err",   err,        0);
    rst_n = 1'b1;

    // ---------------- zero-wait, len=4, start while busy ----------------
    run(16'h0010, 9'd4, 12, 0, 2);
    for (int i = 0; i < 4; i++) begin
      chk("t1_stb", t_stb[i+1], 1);
      chk("t1_adr", t_adr[i+1], e_adr1[i]);
    end
    chk("t1_stb_drop", t_stb[5], 0);
    chk("t1_cyc5", t_cyc[5], 1);
    chk("t1_cyc6", t_cyc[6], 0);
    chk("t1_dv2", t_dv[2], 0);
    chk("t1_dv3", t_dv[3], 1);
    chk("t1_dv6", t_dv[6], 1);
    chk("t1_dv7", t_dv[7], 0);
    chk("t1_done_cyc", first_done(12), 6);
    chk("t1_done_cnt", cnt_done(12), 1);
    chk("t1_err_cnt", cnt_err(12), 0);
    chk("t1_stb_cnt", cnt_stb(12), 4);
    chk("t1_nwords", dq.size(), 4);
    for (int i = 0; i < 4 && i < dq.size(); i++) chk("t1_dat", dq[i], e_dat1[i]);

    // ---------------- one-wait target, len=3 ----------------
    wait_en = 1'b1;
    run(16'h0020, 9'd3, 12, 0, 0);
    for (int i = 0; i < 6; i++) chk("t2_adr", t_adr[i+1], e_adr2[i]);
    chk("t2_stb6", t_stb[6], 1);
    chk("t2_stb7", t_stb[7], 0);
    chk("t2_nwords", dq.size(), 3);
    for (int i = 0; i < 3 && i < dq.size(); i++) chk("t2_dat", dq[i], e_dat2[i]);
    chk("t2_done_cyc", first_done(12), 8);
    chk("t2_done_cnt", cnt_done(12), 1);
    wait_en = 1'b0;

    // ---------------- address wrap ----------------
    run(16'hFFFE, 9'd4, 10, 0, 0);
    for (int i = 0; i < 4; i++) chk("t3_adr", t_adr[i+1], e_adr3[i]);
    chk("t3_nwords", dq.size(), 4);
    for (int i = 0; i < 4 && i < dq.size(); i++) chk("t3_dat", dq[i], e_dat3[i]);
    chk("t3_done_cyc", first_done(10), 6);

    // ---------------- len=0 ----------------
    run(16'h1234, 9'd0, 8, 0, 0);
    chk("t4_done_cyc", first_done(8), 1);
    chk("t4_done_cnt", cnt_done(8), 1);
    chk("t4_cyc_cnt", cnt_cyc(8), 0);
    chk("t4_stb_cnt", cnt_stb(8), 0);
    chk("t4_nwords", dq.size(), 0);
    chk("t4_err_cnt", cnt_err(8), 0);

    // ---------------- no ack, watchdog abort, stray ack ----------------
    ack_en = 1'b0;
    run(16'h0030, 9'd2, 20, 13, 0);
    chk("t5_stb_cnt", cnt_stb(20), 2);
    chk("t5_done_cyc", first_done(20), 11);
    chk("t5_err11", t_err[11], 1);
    chk("t5_err_cnt", cnt_err(20), 1);
    chk("t5_done_cnt", cnt_done(20), 1);
    chk("t5_cyc10", t_cyc[10], 1);
    chk("t5_cyc11", t_cyc[11], 0);
    chk("t5_nwords", dq.size(), 0);
    ack_en = 1'b1;

    // ---------------- reset during DRAIN ----------------
    run(16'h0050, 9'd8, 9, 0, 0);
    chk("t6_cyc_drain", t_cyc[9], 1);
    chk("t6_stb_drain", t_stb[9], 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_cyc_async", bus.cyc, 0);
    chk("t6_busy_async", busy, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    c_done = 0;
    c_dv = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (done) c_done++;
      if (dout_valid) c_dv++;
      force_ack = (k == 2);
    end
    force_ack = 1'b0;
    chk("t6_no_done", c_done, 0);
    chk("t6_no_dv", c_dv, 0);

    run(16'h0040, 9'd2, 8, 0, 0);
    chk("t6_adr1", t_adr[1], 16'h0040);
    chk("t6_adr2", t_adr[2], 16'h0041);
    chk("t6_nwords", dq.size(), 2);
    for (int i = 0; i < 2 && i < dq.size(); i++) chk("t6_dat", dq[i], e_dat6[i]);
    chk("t6_done_cyc", first_done(8), 4);
    chk("t6_err_cnt", cnt_err(8), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_burst_reader.md
WB_BURST_READER -- requirements
Module: wb_burst_reader

Interface
REQ-001 Parameter AW, default 16: Wishbone address width in bits.
REQ-002 Parameter DW, default 16: Wishbone data width in bits.
REQ-003 Parameter LENW, default 9: width of the burst length field; maximum burst is 2**LENW-1 words.
REQ-004 Parameter TIMEOUT, default 255: idle cycles tolerated with outstanding requests before abort; legal range is 1 or more.
REQ-005 Clock and reset are decided: one clock; reset is asynchronous and active-low.
REQ-006 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 Port wb, if_wb.master: pipelined Wishbone initiator (cyc, stb, we, adr, dat_o, ack, stall, dat_i); the interface's own clk/rst are unused.
REQ-009 Port start, input, 1 bit: single-cycle burst request; sampled in IDLE only.
REQ-010 Port base, input, AW bits: first word address, sampled with start.
REQ-011 Port len, input, LENW bits: number of words to read, sampled with start.
REQ-012 Port dout, output, DW bits: registered read data.
REQ-013 Port dout_valid, output, 1 bit: dout holds a new word this cycle.
REQ-014 Port busy, output, 1 bit: high in every state other than IDLE.
REQ-015 Port done, output, 1 bit: one-cycle pulse at burst end, whether normal or aborted.
REQ-016 Port err, output, 1 bit: one-cycle pulse together with done when the burst is aborted by timeout.

Function
REQ-017 FSM states are IDLE, ISSUE and DRAIN.
- IDLE + start + len!=0: latch base and len, go to ISSUE.
- IDLE + start + len==0: done pulse next cycle; no bus activity.
REQ-018 In ISSUE, cyc=1, stb=1, we=0 and dat_o=0; a request is accepted in each cycle with stb & ~stall.
REQ-019 adr starts at base and increments by 1 after each accepted request, wrapping modulo 2**AW.
REQ-020 When the len-th request is accepted, stb drops in the next cycle and the FSM goes to DRAIN; cyc stays high.
REQ-021 The issued and acked counters are LENW bits wide. An ack counts only while acked < issued (or acked < accepted, including a request accepted in the same cycle). Any other ack is ignored and produces no dout_valid.
REQ-022 Each counted ack registers wb.dat_i into dout, with dout_valid=1 in the following cycle.
REQ-023 When acked reaches len, in the next cycle: cyc=0, stb=0, done=1, FSM goes to IDLE.
REQ-024 The watchdog counter clears on each counted ack, each accepted request, and on entry to ISSUE. It increments in all other ISSUE/DRAIN cycles.
REQ-025 When the watchdog reaches TIMEOUT, in the next cycle: cyc=0, stb=0, done=1, err=1, FSM goes to IDLE. Any later acks are ignored.
REQ-026 start while busy is ignored, and the latched base and len are unchanged.
REQ-027 Latency: start in cycle 0 puts cyc/stb in cycle 1; with a zero-wait slave the last dout_valid and done both occur in cycle len+2.

Reset
REQ-028 rst_n low immediately forces IDLE and cyc=stb=we=0; adr=0, dat_o=0, dout=0, dout_valid=0, busy=0, done=0, err=0; all counters 0.
REQ-029 Reset mid-burst discards the burst without a done pulse; acks arriving after reset are ignored.

Verification
REQ-030 Zero-wait slave, base=0x0010, len=4:
- stb high cycles 1-4, adr 0x10, 0x11, 0x12, 0x13.
- dout_valid cycles 3-6 with RAM words 0x10-0x13.
- done cycle 6; cyc low cycle 6.
REQ-031 One-wait slave (stall asserted on the first stb cycle), len=3:
- Each adr is held 2 cycles.
- 3 dout_valid pulses; done after the third; no duplicated or skipped address.
REQ-032 Wrap case, base=0xFFFE, len=4: adr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001; 4 words returned.
REQ-033 len=0: done pulse in cycle 1; cyc, stb and dout_valid never assert; err=0.
REQ-034 Slave never acks, TIMEOUT=8:
- done=1 and err=1 exactly 9 cycles after the last accepted request; cyc drops in the same cycle.
- A later stray ack gives no dout_valid.
REQ-035 rst_n pulsed low during DRAIN of a len=8 burst:
- cyc=0 asynchronously; no done pulse.
- A new start after reset runs normally from its own base.
